// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit: access size encodings,
// the request FSM state type, the latency bound and the load-extension helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Largest legal LATENCY and the counter width needed to hold LATENCY-1.
    localparam int LAT_MAX = 8;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    // Pick the addressed lane(s) out of a 32-bit word and sign/zero extend.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: load_extend = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: load_extend = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Four byte-wide memory lanes sharing one word address. Each lane has its
// own write enable; the read is combinational across all four lanes.
module dmem_byte_ram #(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    localparam int DEPTH = 2 ** AW;

    for (genvar g = 0; g < 4; g++) begin : gen_lane
        logic [7:0] mem [DEPTH];

        // Lane write: storage is deliberately not reset.
        always_ff @(posedge clk_i) begin
            if (we_i[g]) begin
                mem[addr_i] <= wdata_i[8*g +: 8];
            end
        end

        assign rdata_o[8*g +: 8] = mem[addr_i];
    end

endmodule

// File: rtl/data_memory_unit.sv
// Data memory unit: single-outstanding load/store port with a fixed
// response latency. Byte/half/word accesses, little-endian.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of being silently aligned down.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int WORD_AW = ADDR_W - 2;

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       pend_rdata_q;
    logic              pend_err_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic              accept;
    logic              misalign;
    logic [1:0]        eff_off;
    logic              acc_err;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       acc_rdata;

    // Reset wins over a simultaneous request, so nothing is accepted then.
    assign accept    = (state_q == IDLE) && req_valid && !rst;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Decide the effective lane offset: either trap misalignment or align down.
    always_comb begin
        eff_off  = req_addr[1:0];
        misalign = 1'b0;
        case (req_size)
`ifdef DMEM_MISALIGN_TRAP_EN
            SZ_HALF: misalign = req_addr[0];
            SZ_WORD: misalign = (req_addr[1:0] != 2'b00);
`else
            SZ_HALF: eff_off = {req_addr[1], 1'b0};
            SZ_WORD: eff_off = 2'b00;
`endif
            default: ;
        endcase
    end

    assign acc_err   = ((req_addr >> ADDR_W) != 32'd0) || (req_size == SZ_RSVD) || misalign;
    assign acc_rdata = (acc_err || req_we) ? 32'h0
                     : load_extend(ram_rdata, req_size, eff_off, req_unsigned);

    // Steer store data onto the lanes; faulting stores write nothing.
    always_comb begin
        ram_we    = 4'b0000;
        ram_wdata = req_wdata;
        if (accept && req_we && !acc_err) begin
            case (req_size)
                SZ_BYTE: begin
                    ram_we    = 4'b0001 << eff_off;
                    ram_wdata = {4{req_wdata[7:0]}};
                end
                SZ_HALF: begin
                    ram_we    = eff_off[1] ? 4'b1100 : 4'b0011;
                    ram_wdata = {2{req_wdata[15:0]}};
                end
                default: ram_we = 4'b1111;
            endcase
        end
    end

    dmem_byte_ram #(
        .AW(WORD_AW)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (ram_we),
        .addr_i (req_addr[ADDR_W-1:2]),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE, WAIT counts down to 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and response registers; load data is captured at
    // acceptance and published to rsp_rdata as the response starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_rdata_q <= 32'h0;
            pend_err_q   <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pend_rdata_q <= acc_rdata;
                pend_err_q   <= acc_err;
            end
            if (state_d == RESP && state_q != RESP) begin
                rsp_rdata_q <= (state_q == IDLE) ? acc_rdata : pend_rdata_q;
                rsp_err_q   <= (state_q == IDLE) ? acc_err   : pend_err_q;
            end
        end
    end

endmodule
